// File: rtl/otter_pkg.sv
// Shared control-unit definitions: FSM state encoding and RV32I opcode/funct3 constants
// used by the control FSM and the instruction decoder.
package otter_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        INTR  = 3'd4
    } cu_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNC_MRET  = 3'b000;
    localparam logic [2:0] FUNC_CSRRW = 3'b001;

endpackage

// File: rtl/cu_fsm_if.sv
// Memory handshake between the control FSM and the dual-port memory.
// A read enable is held until the matching valid is seen; valid has no effect unless its enable is high.
interface cu_fsm_if;
    logic mem_rden1;
    logic mem_valid1;
    logic mem_rden2;
    logic mem_valid2;
    logic mem_we2;

    modport master (
        output mem_rden1, mem_rden2, mem_we2,
        input  mem_valid1, mem_valid2
    );

    modport slave (
        input  mem_rden1, mem_rden2, mem_we2,
        output mem_valid1, mem_valid2
    );
endinterface

// File: rtl/cu_fsm_instret_counter.sv
// Retired-instruction counter: increments once per completed instruction, wraps naturally.
module instret_counter #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [INSTRET_W-1:0] count
);
    logic [INSTRET_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;
endmodule

// File: rtl/cu_fsm.sv
// Multi-cycle control FSM: INIT -> FETCH -> EXEC [-> WB] -> (INTR) -> FETCH,
// with Mealy-decoded strobes and a retired-instruction counter.
module cu_fsm
    import otter_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           ir_opcode,
    input  logic [2:0]           ir_func,
    input  logic                 intr,
    input  logic                 csr_mie,
    cu_fsm_if.master             mem,
    output logic                 rst_out,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 csr_we,
    output logic                 int_taken,
    output logic                 mret_exec,
    output logic [INSTRET_W-1:0] instret,
    output cu_state_e            dbg_state_o
);
    cu_state_e state_q, state_d;
    logic      rden1, rden2, we2, complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rst_out   = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        rden1     = 1'b0;
        rden2     = 1'b0;
        we2       = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        complete  = 1'b0;
        case (state_q)
            INIT: begin
                rst_out = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                rden1 = 1'b1;
                if (mem.mem_valid1) state_d = EXEC;
            end
            EXEC: begin
                // Everything except a load retires here; unknown opcodes fall through as NOPs.
                complete = 1'b1;
                pc_write = 1'b1;
                case (ir_opcode)
                    OPC_LOAD: begin
                        complete = 1'b0;
                        pc_write = 1'b0;
                        rden2    = 1'b1;
                        state_d  = WB;
                    end
                    OPC_STORE: we2 = 1'b1;
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                        reg_write = 1'b1;
                    OPC_SYSTEM: begin
                        if (ir_func == FUNC_MRET) begin
                            mret_exec = 1'b1;
                        end else if (ir_func == FUNC_CSRRW) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            WB: begin
                rden2 = 1'b1;
                if (mem.mem_valid2) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    complete  = 1'b1;
                end
            end
            INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = INIT;
        endcase
        // Interrupts are only looked at on the retiring cycle.
        if (complete) state_d = (intr && csr_mie) ? INTR : FETCH;
    end

    assign mem.mem_rden1 = rden1;
    assign mem.mem_rden2 = rden2;
    assign mem.mem_we2   = we2;
    assign dbg_state_o   = state_q;

    instret_counter #(.INSTRET_W(INSTRET_W)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (complete),
        .count (instret)
    );
endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: a 32-bit-counter instance and a 4-bit-counter instance
// driven with identical stimulus, table vectors plus hand-written multi-cycle sequences.
module tb_cu_fsm;
    import otter_pkg::*;

    localparam logic [8:0] O_RST  = 9'h100;
    localparam logic [8:0] O_PC   = 9'h080;
    localparam logic [8:0] O_RW   = 9'h040;
    localparam logic [8:0] O_RD1  = 9'h020;
    localparam logic [8:0] O_RD2  = 9'h010;
    localparam logic [8:0] O_WE2  = 9'h008;
    localparam logic [8:0] O_CSR  = 9'h004;
    localparam logic [8:0] O_INT  = 9'h002;
    localparam logic [8:0] O_MRET = 9'h001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] ir_opcode = '0;
    logic [2:0] ir_func = '0;
    logic       intr = 1'b0;
    logic       csr_mie = 1'b0;

    cu_fsm_if mif();
    cu_fsm_if mif4();

    logic        rst_out, pc_write, reg_write, csr_we, int_taken, mret_exec;
    logic [31:0] instret;
    cu_state_e   dbg_state;
    logic        rst_out4, pc_write4, reg_write4, csr_we4, int_taken4, mret_exec4;
    logic [3:0]  instret4;
    cu_state_e   dbg_state4;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_instret = '0;
    logic [31:0] exp_q[$];

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic [2:0] fn;
        logic       irq;
        logic       mie;
        logic [8:0] exp;
        cu_state_e  nxt;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    assign mif4.mem_valid1 = mif.mem_valid1;
    assign mif4.mem_valid2 = mif.mem_valid2;

    cu_fsm #(.INSTRET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ir_func(ir_func),
        .intr(intr), .csr_mie(csr_mie), .mem(mif.master),
        .rst_out(rst_out), .pc_write(pc_write), .reg_write(reg_write), .csr_we(csr_we),
        .int_taken(int_taken), .mret_exec(mret_exec), .instret(instret), .dbg_state_o(dbg_state)
    );

    cu_fsm #(.INSTRET_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ir_func(ir_func),
        .intr(intr), .csr_mie(csr_mie), .mem(mif4.master),
        .rst_out(rst_out4), .pc_write(pc_write4), .reg_write(reg_write4), .csr_we(csr_we4),
        .int_taken(int_taken4), .mret_exec(mret_exec4), .instret(instret4), .dbg_state_o(dbg_state4)
    );

    function automatic logic [8:0] outs();
        return {rst_out, pc_write, reg_write, mif.mem_rden1, mif.mem_rden2, mif.mem_we2,
                csr_we, int_taken, mret_exec};
    endfunction

    function automatic logic [8:0] outs4();
        return {rst_out4, pc_write4, reg_write4, mif4.mem_rden1, mif4.mem_rden2, mif4.mem_we2,
                csr_we4, int_taken4, mret_exec4};
    endfunction

    // Store and load strobes must never overlap; the narrow instance must track the wide one.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((mif.mem_we2 && mif.mem_rden2) || outs4() !== outs()
                || dbg_state4 !== dbg_state) begin
                errors++;
                $display("FAIL invariant: outs=%09b outs4=%09b state=%0d state4=%0d",
                         outs(), outs4(), dbg_state, dbg_state4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [8:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s outs: got=%09b want=%09b", name, outs(), exp);
        end
    endtask

    task automatic check_state(input string name, input cu_state_e exp);
        checks++;
        if (dbg_state !== exp) begin
            errors++;
            $display("FAIL %s state: got=%0d want=%0d", name, dbg_state, exp);
        end
    endtask

    task automatic check_instret(input string name);
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if (instret !== e || instret4 !== e[3:0]) begin
            errors++;
            $display("FAIL %s instret: got=%0d/%0d want=%0d/%0d", name, instret, instret4,
                     e, e[3:0]);
        end
    endtask

    task automatic retire();
        exp_instret = exp_instret + 32'd1;
        exp_q.push_back(exp_instret);
    endtask

    // Entered just after an edge with the FSM in FETCH; leaves it in EXEC.
    task automatic run_fetch(input string name, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            mif.mem_valid1 = 1'b0;
            @(negedge clk);
            check_outs({name, " fetch-wait"}, O_RD1);
            tick();
        end
        mif.mem_valid1 = 1'b1;
        @(negedge clk);
        check_state({name, " fetch"}, FETCH);
        check_outs({name, " fetch"}, O_RD1);
        tick();
        mif.mem_valid1 = 1'b0;
    endtask

    task automatic do_vec(input vec_t v, input int wait_cycles);
        ir_opcode = v.opc;
        ir_func   = v.fn;
        run_fetch(v.name, wait_cycles);
        intr    = v.irq;
        csr_mie = v.mie;
        @(negedge clk);
        check_state({v.name, " exec"}, EXEC);
        check_outs({v.name, " exec"}, v.exp);
        tick();
        retire();
        check_state({v.name, " next"}, v.nxt);
        check_instret(v.name);
        if (v.nxt == INTR) begin
            // intr left high through INTR: it must not be sampled there
            @(negedge clk);
            check_outs({v.name, " intr"}, O_INT | O_PC);
            tick();
            exp_q.push_back(exp_instret);
            check_state({v.name, " after-intr"}, FETCH);
            check_instret({v.name, " after-intr"});
        end
        intr    = 1'b0;
        csr_mie = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check_state("release init", INIT);
        check_outs("release init", O_RST);
        tick();
        check_state("release fetch", FETCH);
    endtask

    initial begin
        vecs[0]  = '{"addi",     OPC_OP_IMM, 3'b000, 1'b0, 1'b0, O_RW | O_PC,          FETCH};
        vecs[1]  = '{"add",      OPC_OP,     3'b000, 1'b0, 1'b0, O_RW | O_PC,          FETCH};
        vecs[2]  = '{"lui",      OPC_LUI,    3'b000, 1'b0, 1'b0, O_RW | O_PC,          FETCH};
        vecs[3]  = '{"auipc",    OPC_AUIPC,  3'b000, 1'b0, 1'b0, O_RW | O_PC,          FETCH};
        vecs[4]  = '{"jal",      OPC_JAL,    3'b000, 1'b0, 1'b0, O_RW | O_PC,          FETCH};
        vecs[5]  = '{"jalr",     OPC_JALR,   3'b000, 1'b0, 1'b0, O_RW | O_PC,          FETCH};
        vecs[6]  = '{"sw",       OPC_STORE,  3'b010, 1'b0, 1'b0, O_WE2 | O_PC,         FETCH};
        vecs[7]  = '{"beq",      OPC_BRANCH, 3'b000, 1'b0, 1'b0, O_PC,                 FETCH};
        vecs[8]  = '{"mret",     OPC_SYSTEM, 3'b000, 1'b0, 1'b0, O_MRET | O_PC,        FETCH};
        vecs[9]  = '{"csrrw",    OPC_SYSTEM, 3'b001, 1'b0, 1'b0, O_CSR | O_RW | O_PC,  FETCH};
        vecs[10] = '{"csrrs",    OPC_SYSTEM, 3'b010, 1'b0, 1'b0, O_PC,                 FETCH};
        vecs[11] = '{"illegal",  7'b0000000, 3'b000, 1'b0, 1'b0, O_PC,                 FETCH};
        vecs[12] = '{"add-irq",  OPC_OP,     3'b000, 1'b1, 1'b1, O_RW | O_PC,          INTR};
        vecs[13] = '{"add-nomie",OPC_OP,     3'b000, 1'b1, 1'b0, O_RW | O_PC,          FETCH};

        mif.mem_valid1 = 1'b0;
        mif.mem_valid2 = 1'b0;

        // Held in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("reset", INIT);
        check_outs("reset", O_RST);
        exp_q.push_back(32'd0);
        check_instret("reset");

        tick();
        release_reset();

        // ADDI with valid1 arriving one cycle after the fetch request
        do_vec(vecs[0], 1);

        for (int i = 1; i < 14; i++) do_vec(vecs[i], i % 3);

        // LW with valid2 delayed three cycles
        ir_opcode = OPC_LOAD;
        ir_func   = 3'b010;
        run_fetch("lw", 0);
        @(negedge clk);
        check_outs("lw exec", O_RD2);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_state("lw wb-stall", WB);
            check_outs("lw wb-stall", O_RD2);
            tick();
        end
        mif.mem_valid2 = 1'b1;
        @(negedge clk);
        check_state("lw wb-done", WB);
        check_outs("lw wb-done", O_RD2 | O_RW | O_PC);
        tick();
        mif.mem_valid2 = 1'b0;
        retire();
        check_state("lw next", FETCH);
        check_instret("lw");

        // Interrupt pulse outside the completion cycle is dropped
        ir_opcode = OPC_OP;
        ir_func   = 3'b000;
        intr      = 1'b1;
        csr_mie   = 1'b1;
        mif.mem_valid1 = 1'b1;
        tick();
        mif.mem_valid1 = 1'b0;
        intr = 1'b0;
        @(negedge clk);
        check_outs("pulse exec", O_RW | O_PC);
        tick();
        retire();
        csr_mie = 1'b0;
        check_state("pulse next", FETCH);
        check_instret("pulse");

        // Reset in the middle of a WB stall
        ir_opcode = OPC_LOAD;
        run_fetch("lw-rst", 0);
        tick();
        tick();
        check_state("lw-rst stall", WB);
        rst_n = 1'b0;
        #1;
        check_state("lw-rst abort", INIT);
        check_outs("lw-rst abort", O_RST);
        exp_instret = '0;
        exp_q.push_back(32'd0);
        check_instret("lw-rst abort");
        tick();
        release_reset();

        // 17 ADDIs: the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) do_vec(vecs[0], 0);
        checks++;
        if (instret4 !== 4'd1 || instret !== 32'd17) begin
            errors++;
            $display("FAIL wrap: got=%0d/%0d want=17/1", instret, instret4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cu_fsm.md
CU_FSM -- requirements
Module: cu_fsm

Interface
REQ-001 Parameter INSTRET_W, default 32, width of the retired-instruction counter.
REQ-002 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port ir_opcode, input, 7, opcode field of the current instruction register.
REQ-005 Port ir_func, input, 3, funct3 field of the current instruction register.
REQ-006 Port intr, input, 1, external interrupt request, level-sensitive.
REQ-007 Port csr_mie, input, 1, machine interrupt enable from the CSR file.
REQ-008 Port mem_valid1, input, 1, instruction-port read data valid.
REQ-009 Port mem_valid2, input, 1, data-port read data valid.
REQ-010 Port rst_out, output, 1, synchronous reset to the PC and register file.
REQ-011 Port pc_write, output, 1, PC register load enable.
REQ-012 Port reg_write, output, 1, register-file write enable.
REQ-013 Port mem_rden1, output, 1, instruction fetch read enable.
REQ-014 Port mem_rden2, output, 1, data read enable.
REQ-015 Port mem_we2, output, 1, data write enable.
REQ-016 Port csr_we, output, 1, CSR write enable.
REQ-017 Port int_taken, output, 1, interrupt-entry strobe to the decoder and CSR file.
REQ-018 Port mret_exec, output, 1, MRET execution strobe.
REQ-019 Port instret, output, INSTRET_W, count of retired instructions.

Function
REQ-020 States: INIT, FETCH, EXEC, WB, INTR; outputs are decoded combinationally from the state and the inputs; each output is 0 unless a rule below sets it.
REQ-021 INIT: rst_out=1; next state is FETCH unconditionally.
REQ-022 FETCH: mem_rden1=1; hold in FETCH while mem_valid1=0; go to EXEC on the cycle mem_valid1=1.
REQ-023 EXEC, load (0000011): mem_rden2=1, pc_write=0; next state is WB.
REQ-024 EXEC, store (0100011): mem_we2=1, pc_write=1.
REQ-025 EXEC, branch (1100011): pc_write=1.
REQ-026 EXEC, R-type, I-type ALU, LUI, AUIPC, JAL, JALR: reg_write=1, pc_write=1.
REQ-027 EXEC, SYSTEM (1110011), ir_func=000: mret_exec=1, pc_write=1.
REQ-028 EXEC, SYSTEM, ir_func=001 (CSRRW): csr_we=1, reg_write=1, pc_write=1.
REQ-029 EXEC, any other opcode or SYSTEM funct3: treated as a NOP, so pc_write=1 only.
REQ-030 WB: hold in WB while mem_valid2=0 with mem_rden2=1 and all other outputs 0; when mem_valid2=1, reg_write=1 and pc_write=1.
REQ-031 The completion cycle is a non-load EXEC cycle or a WB cycle with mem_valid2=1; instret increments by 1 on that cycle and wraps modulo 2^INSTRET_W.
REQ-032 At completion, the next state is INTR if intr=1 and csr_mie=1; otherwise it is FETCH.
REQ-033 INTR: int_taken=1, pc_write=1 for exactly one cycle; next state is FETCH; intr is not sampled in INTR; instret does not increment.
REQ-034 Interrupts are sampled only at completion; intr pulses that fall outside completion cycles are not latched.
REQ-035 mem_we2 and mem_rden2 are never 1 in the same cycle; pc_write is 1 at most once per instruction.

Reset
REQ-036 While rst_n=0: state=INIT, instret=0, rst_out=1, all other outputs 0.
REQ-037 Assertion of rst_n in any state, including a FETCH or WB stall, aborts the instruction immediately with no write strobe.
REQ-038 After rst_n deasserts, the first edge leaves INIT and the second cycle is FETCH.

Structure
REQ-039 Package otter_pkg holds the opcode constants and the state enum (INIT, FETCH, EXEC, WB, INTR) shared with the decoder.
REQ-040 The retired-instruction counter is a sub-module instret_counter with inputs clk, rst_n and inc, and parameter INSTRET_W.

Verification
REQ-041 Reset release, then ADDI with mem_valid1 high one cycle after mem_rden1: sequence INIT, FETCH, EXEC with reg_write=pc_write=1, then FETCH; instret=1.
REQ-042 LW with mem_valid2 delayed 3 cycles: WB held 3 cycles with reg_write=0; reg_write=pc_write=1 on the 4th cycle; instret increments exactly once.
REQ-043 SW, then BEQ: mem_we2=1 only in the SW EXEC cycle and reg_write=0 throughout; the BEQ EXEC cycle gives pc_write=1 only.
REQ-044 intr=1, csr_mie=1 during an ADD EXEC: next cycle is INTR with int_taken=pc_write=1, then FETCH; with csr_mie=0 there is no INTR.
REQ-045 rst_n pulled low mid-WB stall: state=INIT and instret=0 immediately, with no reg_write.
REQ-046 INSTRET_W=4, 17 ADDIs: instret wraps to 1.
